multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle main control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives the strobes that move data through the shared datapath. It generates the `ALUcontrol`/`IRtype`/`BranchEn`/`IsUncond` inputs of the ALU operation signal generator, handles the memory request/ready handshake, and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `CLK` in 1: single clock, all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high.
- `Opcode` in 7: `IR[6:0]`, valid from DECODE onward.
- `MemReady` in 1: memory completes the current request in a cycle where `MemReq` and `MemReady` are both 1.
- `BranchTaken` in 1: branch comparator result, valid in EXEC.
- `MemReq` out 1: memory request.
- `MemWrite` out 1: store qualifier.
- `IorD` out 1: address source, 0 = PC, 1 = ALUout.
- `IRwrite` out 1: load IR.
- `MDRwrite` out 1: load memory data register.
- `ALUoutWrite` out 1: load ALUout.
- `RegWrite` out 1: register file write.
- `PCwrite` out 1: load PC.
- `PCsrc` out 2: 00 = PC+4, 01 = ALUout, 10 = branch target.
- `ALUsrcA` out 2: 00 = rs1, 01 = PC, 10 = zero.
- `ALUsrcB` out 1: 0 = rs2, 1 = immediate.
- `WBsel` out 2: 00 = ALUout, 01 = MDR, 10 = PC+4.
- `ALUcontrol`, `IRtype`, `BranchEn`, `IsUncond` out 1 each: drive the ALU operation unit.
- `Retire` out 1: one-cycle pulse per completed instruction.
- `InstRet` out `CNT_W`: retired-instruction count.
- `Halted` out 1: illegal opcode trap.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Opcode class is latched in DECODE and held through the instruction.
- **Reset:** state goes to FETCH, `InstRet` = 0, `Halted` = 0. Every output strobe is 0 while RESET is high. RESET mid-instruction abandons it, and no PC or register write occurs that cycle.
- **FETCH:** `MemReq` = 1, `IorD` = 0. FETCH is held while `MemReady` = 0. When `MemReady` = 1: `IRwrite` = 1, go to DECODE.
- **DECODE** (1 cycle):
  - Legal opcodes: OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, FENCE 0001111.
  - FENCE goes to WB as a NOP. Any other legal opcode goes to EXEC. Anything else goes to TRAP.
- **EXEC** (1 cycle): `ALUoutWrite` = 1 for every class except BRANCH.
  - OP: `ALUcontrol` = 1, `IRtype` = 0, srcA rs1, srcB rs2.
  - OP-IMM: `ALUcontrol` = 1, `IRtype` = 1, srcB imm.
  - LOAD/STORE: ADD, rs1 + imm.
  - LUI: srcA zero + imm.
  - AUIPC: srcA PC + imm.
  - JAL: `BranchEn` = 1, `IsUncond` = 1, srcA PC + imm.
  - JALR: `BranchEn` = 1, `IsUncond` = 1, srcA rs1 + imm.
  - BRANCH: `BranchEn` = 1, `IsUncond` = 0, srcA rs1, srcB rs2. `PCwrite` = 1, `PCsrc` = 10 if `BranchTaken`, else 00. `Retire` = 1, go to FETCH.
  - LOAD/STORE go to MEM. All others go to WB.
- **MEM:** `MemReq` = 1, `IorD` = 1, `MemWrite` = 1 for STORE. MEM is held while `MemReady` = 0.
  - LOAD: on ready, `MDRwrite` = 1, go to WB.
  - STORE: on ready, `PCwrite` = 1, `PCsrc` = 00, `Retire` = 1, go to FETCH.
- **WB** (1 cycle): `PCwrite` = 1, `Retire` = 1, go to FETCH. `PCsrc` = 00 except JAL/JALR, which use 01. Register write per class:
  - OP, OP-IMM, LUI, AUIPC: `RegWrite` = 1, `WBsel` = 00.
  - LOAD: `RegWrite` = 1, `WBsel` = 01.
  - JAL/JALR: `RegWrite` = 1, `WBsel` = 10.
  - FENCE: `RegWrite` = 0.
- **TRAP:** `Halted` = 1. All strobes are 0. TRAP is left only by RESET.
- `ALUcontrol`, `BranchEn` and `IsUncond` are 0 outside EXEC. `MemReq` is never asserted outside FETCH and MEM.
- `InstRet` increments by 1 on each `Retire` and wraps modulo 2^`CNT_W`.

## Timing
- Outputs are combinational from state and latched class. The only exception is that handshake strobes (`IRwrite`, `MDRwrite`, store-completion `PCwrite`/`Retire`) are qualified by `MemReady`.
- Cycles per instruction with zero wait (`MemReady` = 1 on the first request cycle):

  | Class | Cycles |
  |---|---|
  | BRANCH | 3 |
  | OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE | 4 |
  | LOAD | 5 |
  | FENCE | 3 |

  Each memory wait cycle adds 1.
- `Retire` is high in exactly the last cycle of an instruction. `InstRet` shows the increment the following cycle.
- `MemReq` stays high continuously until accepted and is never dropped mid-wait. The next FETCH may assert `MemReq` in the cycle immediately after store completion.

## Test plan
- **R-type `add`, zero wait:** 4 cycles.
  - EXEC: `ALUcontrol` = 1, `IRtype` = 0.
  - WB: `RegWrite` = 1, `WBsel` = 00, `PCwrite` = 1, `PCsrc` = 00.
  - Result: `InstRet` 0 → 1.
- **LOAD with `MemReady` low for 2 cycles in FETCH and 3 in MEM:** completes in 10 cycles. `MemReq` is continuous during each wait. `MDRwrite` pulses once, then `RegWrite` with `WBsel` = 01.
- **BRANCH taken, then not taken:** EXEC shows `BranchEn` = 1, `IsUncond` = 0, `PCwrite` = 1, with `PCsrc` = 10 then 00. `RegWrite` stays 0. 3 cycles each.
- **JAL then JALR:** EXEC shows `IsUncond` = 1. WB shows `WBsel` = 10, `PCsrc` = 01, `RegWrite` = 1.
- **Opcode 1111111:** DECODE goes to TRAP, `Halted` = 1 with no further strobes over 20 cycles. RESET clears it: FETCH, `Halted` = 0, `InstRet` = 0.
- **RESET asserted in MEM of a STORE:** no `PCwrite` or `Retire` that cycle. The next cycle is FETCH with `IorD` = 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multi-cycle control FSM (master) and the datapath/memory side (slave).
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Opcode;
    logic             MemReady;
    logic             BranchTaken;
    logic             MemReq;
    logic             MemWrite;
    logic             IorD;
    logic             IRwrite;
    logic             MDRwrite;
    logic             ALUoutWrite;
    logic             RegWrite;
    logic             PCwrite;
    logic [1:0]       PCsrc;
    logic [1:0]       ALUsrcA;
    logic             ALUsrcB;
    logic [1:0]       WBsel;
    logic             ALUcontrol;
    logic             IRtype;
    logic             BranchEn;
    logic             IsUncond;
    logic             Retire;
    logic [CNT_W-1:0] InstRet;
    logic             Halted;

    modport master (
        input  Opcode, MemReady, BranchTaken,
        output MemReq, MemWrite, IorD, IRwrite, MDRwrite, ALUoutWrite, RegWrite,
               PCwrite, PCsrc, ALUsrcA, ALUsrcB, WBsel, ALUcontrol, IRtype,
               BranchEn, IsUncond, Retire, InstRet, Halted
    );

    modport slave (
        output Opcode, MemReady, BranchTaken,
        input  MemReq, MemWrite, IorD, IRwrite, MDRwrite, ALUoutWrite, RegWrite,
               PCwrite, PCsrc, ALUsrcA, ALUsrcB, WBsel, ALUcontrol, IRtype,
               BranchEn, IsUncond, Retire, InstRet, Halted
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath strobes and counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_OP,
        C_OPIMM,
        C_LUI,
        C_AUIPC,
        C_JAL,
        C_JALR,
        C_BRANCH,
        C_LOAD,
        C_STORE,
        C_FENCE,
        C_ILLEGAL
    } class_t;

    state_t           stateQ, stateD;
    class_t           classQ, classD, decClass;
    logic [CNT_W-1:0] instRetQ;

    always_comb begin
        case (bus.Opcode)
            7'b0110011: decClass = C_OP;
            7'b0010011: decClass = C_OPIMM;
            7'b0110111: decClass = C_LUI;
            7'b0010111: decClass = C_AUIPC;
            7'b1101111: decClass = C_JAL;
            7'b1100111: decClass = C_JALR;
            7'b1100011: decClass = C_BRANCH;
            7'b0000011: decClass = C_LOAD;
            7'b0100011: decClass = C_STORE;
            7'b0001111: decClass = C_FENCE;
            default:    decClass = C_ILLEGAL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stateQ   <= S_FETCH;
            classQ   <= C_FENCE;
            instRetQ <= '0;
        end else begin
            stateQ <= stateD;
            classQ <= classD;
            if (bus.Retire) begin
                instRetQ <= instRetQ + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Strobes stay low during RESET so an abandoned instruction never writes PC or registers.
    always_comb begin
        stateD          = stateQ;
        classD          = classQ;
        bus.MemReq      = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IorD        = 1'b0;
        bus.IRwrite     = 1'b0;
        bus.MDRwrite    = 1'b0;
        bus.ALUoutWrite = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.PCwrite     = 1'b0;
        bus.PCsrc       = 2'b00;
        bus.ALUsrcA     = 2'b00;
        bus.ALUsrcB     = 1'b0;
        bus.WBsel       = 2'b00;
        bus.ALUcontrol  = 1'b0;
        bus.IRtype      = 1'b0;
        bus.BranchEn    = 1'b0;
        bus.IsUncond    = 1'b0;
        bus.Retire      = 1'b0;
        bus.Halted      = 1'b0;
        if (!RESET) begin
            case (stateQ)
                S_FETCH: begin
                    bus.MemReq = 1'b1;
                    if (bus.MemReady) begin
                        bus.IRwrite = 1'b1;
                        stateD      = S_DECODE;
                    end
                end
                S_DECODE: begin
                    classD = decClass;
                    case (decClass)
                        C_FENCE:   stateD = S_WB;
                        C_ILLEGAL: stateD = S_TRAP;
                        default:   stateD = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    bus.ALUoutWrite = (classQ != C_BRANCH);
                    stateD          = S_WB;
                    case (classQ)
                        C_OP: begin
                            bus.ALUcontrol = 1'b1;
                        end
                        C_OPIMM: begin
                            bus.ALUcontrol = 1'b1;
                            bus.IRtype     = 1'b1;
                            bus.ALUsrcB    = 1'b1;
                        end
                        C_LOAD, C_STORE: begin
                            bus.ALUsrcB = 1'b1;
                            stateD      = S_MEM;
                        end
                        C_LUI: begin
                            bus.ALUsrcA = 2'b10;
                            bus.ALUsrcB = 1'b1;
                        end
                        C_AUIPC: begin
                            bus.ALUsrcA = 2'b01;
                            bus.ALUsrcB = 1'b1;
                        end
                        C_JAL: begin
                            bus.BranchEn = 1'b1;
                            bus.IsUncond = 1'b1;
                            bus.ALUsrcA  = 2'b01;
                            bus.ALUsrcB  = 1'b1;
                        end
                        C_JALR: begin
                            bus.BranchEn = 1'b1;
                            bus.IsUncond = 1'b1;
                            bus.ALUsrcB  = 1'b1;
                        end
                        C_BRANCH: begin
                            bus.BranchEn = 1'b1;
                            bus.PCwrite  = 1'b1;
                            bus.PCsrc    = bus.BranchTaken ? 2'b10 : 2'b00;
                            bus.Retire   = 1'b1;
                            stateD       = S_FETCH;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.MemReq   = 1'b1;
                    bus.IorD     = 1'b1;
                    bus.MemWrite = (classQ == C_STORE);
                    if (bus.MemReady) begin
                        if (classQ == C_STORE) begin
                            bus.PCwrite = 1'b1;
                            bus.Retire  = 1'b1;
                            stateD      = S_FETCH;
                        end else begin
                            bus.MDRwrite = 1'b1;
                            stateD       = S_WB;
                        end
                    end
                end
                S_WB: begin
                    bus.PCwrite = 1'b1;
                    bus.Retire  = 1'b1;
                    stateD      = S_FETCH;
                    case (classQ)
                        C_OP, C_OPIMM, C_LUI, C_AUIPC: begin
                            bus.RegWrite = 1'b1;
                        end
                        C_LOAD: begin
                            bus.RegWrite = 1'b1;
                            bus.WBsel    = 2'b01;
                        end
                        C_JAL, C_JALR: begin
                            bus.RegWrite = 1'b1;
                            bus.WBsel    = 2'b10;
                            bus.PCsrc    = 2'b01;
                        end
                        default: ;
                    endcase
                end
                S_TRAP: begin
                    bus.Halted = 1'b1;
                end
                default: begin
                    stateD = S_FETCH;
                end
            endcase
        end
    end

    assign bus.InstRet = instRetQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction model
// built from opcode-class rules (cycle counts, strobe counts, selector values).
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] FENCE  = 7'b0001111;

    logic CLK;
    logic RESET;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(.CNT_W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelRet;

    int          obsCycles;
    bit          obsTimeout;
    int          nIR, nMDR, nReg, nPCw, nRet, nMemReq, nMemWr, nALUo, nBrEn, nHalt;
    logic [1:0]  obsWbSel, obsPcSrc;
    logic [31:0] obsRetStart;
    logic        eAluCtl, eIRtype, eBrEn, eUncond, eSrcB;
    logic [1:0]  eSrcA;

    // Reference rules per opcode class
    function automatic bit isMem(input logic [6:0] op);
        return (op == LOAD) || (op == STORE);
    endfunction

    function automatic int expCycles(input logic [6:0] op, input int fw, input int mw);
        int base;
        case (op)
            BRANCH, FENCE: base = 3;
            LOAD:          base = 5;
            default:       base = 4;
        endcase
        return base + fw + (isMem(op) ? mw : 0);
    endfunction

    function automatic bit expRegWrite(input logic [6:0] op);
        return !(op == BRANCH || op == STORE || op == FENCE);
    endfunction

    function automatic logic [1:0] expWbSel(input logic [6:0] op);
        if (op == LOAD) return 2'b01;
        if (op == JAL || op == JALR) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] expPcSrc(input logic [6:0] op, input logic taken);
        if (op == BRANCH) return taken ? 2'b10 : 2'b00;
        if (op == JAL || op == JALR) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] expSrcA(input logic [6:0] op);
        if (op == LUI) return 2'b10;
        if (op == AUIPC || op == JAL) return 2'b01;
        return 2'b00;
    endfunction

    task automatic applyStimulus(input logic [6:0] op, input int fw, input int mw, input logic taken);
        int cyc;
        int reqIdx;
        int waitCnt;
        bit done;
        bus.Opcode      = op;
        bus.BranchTaken = taken;
        {nIR, nMDR, nReg, nPCw, nRet, nMemReq, nMemWr, nALUo, nBrEn, nHalt} = '0;
        obsWbSel = 2'bxx;
        obsPcSrc = 2'bxx;
        obsTimeout = 1'b0;
        cyc = 0; reqIdx = 0; waitCnt = 0; done = 1'b0;
        while (!done) begin
            @(posedge CLK);
            #1;
            if (bus.MemReq === 1'b1) bus.MemReady = (waitCnt >= ((reqIdx == 0) ? fw : mw));
            else bus.MemReady = 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) obsRetStart = bus.InstRet;
            if (cyc == fw + 2) begin
                eAluCtl = bus.ALUcontrol; eIRtype = bus.IRtype; eBrEn = bus.BranchEn;
                eUncond = bus.IsUncond;   eSrcA = bus.ALUsrcA;  eSrcB = bus.ALUsrcB;
            end
            nIR += int'(bus.IRwrite);      nMDR += int'(bus.MDRwrite);  nReg += int'(bus.RegWrite);
            nPCw += int'(bus.PCwrite);     nRet += int'(bus.Retire);    nMemReq += int'(bus.MemReq);
            nMemWr += int'(bus.MemWrite);  nALUo += int'(bus.ALUoutWrite);
            nBrEn += int'(bus.BranchEn);   nHalt += int'(bus.Halted);
            if (bus.RegWrite === 1'b1) obsWbSel = bus.WBsel;
            if (bus.PCwrite === 1'b1) obsPcSrc = bus.PCsrc;
            if (bus.MemReq === 1'b1) begin
                if (bus.MemReady) begin reqIdx++; waitCnt = 0; end
                else waitCnt++;
            end
            cyc++;
            if (bus.Retire === 1'b1) done = 1'b1;
            else if (cyc >= 64) begin done = 1'b1; obsTimeout = 1'b1; end
        end
        obsCycles = cyc;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.MemReady = 1'b0;
        bus.Opcode = OP_R;
        bus.BranchTaken = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if ({bus.MemReq, bus.IRwrite, bus.PCwrite, bus.RegWrite, bus.Retire, bus.MemWrite, bus.Halted} !== 7'd0) begin
            errors++; $display("[TB] FAIL reset_strobes: got %b expected 0000000",
                {bus.MemReq, bus.IRwrite, bus.PCwrite, bus.RegWrite, bus.Retire, bus.MemWrite, bus.Halted});
        end
        checks++;
        if (bus.InstRet !== 32'd0) begin errors++; $display("[TB] FAIL reset_instret: got %0d expected 0", bus.InstRet); end
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.MemReq, bus.IorD} !== 2'b10) begin
            errors++; $display("[TB] FAIL reset_fetch: got MemReq/IorD %b expected 10", {bus.MemReq, bus.IorD});
        end
        modelRet = 32'd0;
    endtask

    task automatic test_add();
        applyStimulus(OP_R, 0, 0, 1'b0);
        checks++;
        if (obsCycles !== 4) begin errors++; $display("[TB] FAIL add_cycles: got %0d expected 4", obsCycles); end
        checks++;
        if ({eAluCtl, eIRtype} !== 2'b10) begin errors++; $display("[TB] FAIL add_exec_alu: got %b expected 10", {eAluCtl, eIRtype}); end
        checks++;
        if (nReg !== 1 || obsWbSel !== 2'b00) begin errors++; $display("[TB] FAIL add_wb: got reg %0d wbsel %b expected 1 00", nReg, obsWbSel); end
        checks++;
        if (nPCw !== 1 || obsPcSrc !== 2'b00) begin errors++; $display("[TB] FAIL add_pc: got pcw %0d pcsrc %b expected 1 00", nPCw, obsPcSrc); end
        checks++;
        if (obsRetStart !== modelRet) begin errors++; $display("[TB] FAIL add_instret_start: got %0d expected %0d", obsRetStart, modelRet); end
        modelRet++;
    endtask

    task automatic test_load_waits();
        applyStimulus(LOAD, 2, 3, 1'b0);
        checks++;
        if (obsRetStart !== modelRet) begin errors++; $display("[TB] FAIL load_instret_start: got %0d expected %0d", obsRetStart, modelRet); end
        checks++;
        if (obsCycles !== 10) begin errors++; $display("[TB] FAIL load_cycles: got %0d expected 10", obsCycles); end
        checks++;
        if (nMemReq !== 7) begin errors++; $display("[TB] FAIL load_memreq_cycles: got %0d expected 7", nMemReq); end
        checks++;
        if (nMDR !== 1) begin errors++; $display("[TB] FAIL load_mdrwrite: got %0d expected 1", nMDR); end
        checks++;
        if (nReg !== 1 || obsWbSel !== 2'b01) begin errors++; $display("[TB] FAIL load_wb: got reg %0d wbsel %b expected 1 01", nReg, obsWbSel); end
        modelRet++;
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            applyStimulus(BRANCH, 0, 0, 1'(t));
            checks++;
            if (obsCycles !== 3) begin errors++; $display("[TB] FAIL branch_cycles: taken %0d got %0d expected 3", t, obsCycles); end
            checks++;
            if ({eBrEn, eUncond} !== 2'b10) begin errors++; $display("[TB] FAIL branch_exec: got %b expected 10", {eBrEn, eUncond}); end
            checks++;
            if (nPCw !== 1 || obsPcSrc !== (t != 0 ? 2'b10 : 2'b00)) begin
                errors++; $display("[TB] FAIL branch_pc: taken %0d got pcw %0d pcsrc %b", t, nPCw, obsPcSrc);
            end
            checks++;
            if (nReg !== 0) begin errors++; $display("[TB] FAIL branch_regwrite: got %0d expected 0", nReg); end
            modelRet++;
        end
    endtask

    task automatic test_jal_jalr();
        logic [6:0] ops [2];
        ops[0] = JAL;
        ops[1] = JALR;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(ops[i], 1, 0, 1'b0);
            checks++;
            if ({eBrEn, eUncond} !== 2'b11) begin errors++; $display("[TB] FAIL jump_exec: op %b got %b expected 11", ops[i], {eBrEn, eUncond}); end
            checks++;
            if (nReg !== 1 || obsWbSel !== 2'b10 || obsPcSrc !== 2'b01) begin
                errors++; $display("[TB] FAIL jump_wb: op %b got reg %0d wbsel %b pcsrc %b expected 1 10 01", ops[i], nReg, obsWbSel, obsPcSrc);
            end
            checks++;
            if (obsCycles !== 5) begin errors++; $display("[TB] FAIL jump_cycles: got %0d expected 5", obsCycles); end
            modelRet++;
        end
    endtask

    task automatic test_back_to_back(input int count);
        logic [6:0] legal [10];
        logic [6:0] op;
        int         fw, mw;
        logic       taken;
        legal = '{OP_R, OP_I, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, FENCE};
        for (int n = 0; n < count; n++) begin
            op    = legal[$urandom_range(0, 9)];
            fw    = $urandom_range(0, 3);
            mw    = $urandom_range(0, 3);
            taken = 1'($urandom_range(0, 1));
            applyStimulus(op, fw, mw, taken);
            checks++;
            if (obsTimeout) begin errors++; $display("[TB] FAIL rnd_timeout: op %b got no Retire in 64 cycles", op); end
            checks++;
            if (obsCycles !== expCycles(op, fw, mw)) begin
                errors++; $display("[TB] FAIL rnd_cycles: op %b fw %0d mw %0d got %0d expected %0d", op, fw, mw, obsCycles, expCycles(op, fw, mw));
            end
            checks++;
            if (obsRetStart !== modelRet) begin errors++; $display("[TB] FAIL rnd_instret: got %0d expected %0d", obsRetStart, modelRet); end
            checks++;
            if (nIR !== 1 || nRet !== 1 || nPCw !== 1) begin
                errors++; $display("[TB] FAIL rnd_pulses: op %b got ir %0d ret %0d pcw %0d expected 1 1 1", op, nIR, nRet, nPCw);
            end
            checks++;
            if (obsPcSrc !== expPcSrc(op, taken)) begin errors++; $display("[TB] FAIL rnd_pcsrc: op %b got %b expected %b", op, obsPcSrc, expPcSrc(op, taken)); end
            checks++;
            if (nReg !== int'(expRegWrite(op))) begin errors++; $display("[TB] FAIL rnd_regwrite: op %b got %0d expected %0d", op, nReg, expRegWrite(op)); end
            if (expRegWrite(op)) begin
                checks++;
                if (obsWbSel !== expWbSel(op)) begin errors++; $display("[TB] FAIL rnd_wbsel: op %b got %b expected %b", op, obsWbSel, expWbSel(op)); end
            end
            checks++;
            if (nMemReq !== fw + 1 + (isMem(op) ? mw + 1 : 0)) begin
                errors++; $display("[TB] FAIL rnd_memreq: op %b got %0d expected %0d", op, nMemReq, fw + 1 + (isMem(op) ? mw + 1 : 0));
            end
            checks++;
            if (nMemWr !== ((op == STORE) ? mw + 1 : 0) || nMDR !== int'(op == LOAD)) begin
                errors++; $display("[TB] FAIL rnd_mem_strobes: op %b got memwrite %0d mdr %0d", op, nMemWr, nMDR);
            end
            checks++;
            if (nALUo !== int'(op != BRANCH && op != FENCE) || nHalt !== 0) begin
                errors++; $display("[TB] FAIL rnd_aluout_halt: op %b got aluout %0d halted %0d", op, nALUo, nHalt);
            end
            if (op != FENCE) begin
                checks++;
                if ({eAluCtl, eBrEn, eUncond, eSrcA, eSrcB} !==
                    {(op == OP_R || op == OP_I), (op == JAL || op == JALR || op == BRANCH), (op == JAL || op == JALR),
                     expSrcA(op), !(op == OP_R || op == BRANCH)}) begin
                    errors++; $display("[TB] FAIL rnd_exec: op %b got alu %b br %b unc %b srcA %b srcB %b",
                        op, eAluCtl, eBrEn, eUncond, eSrcA, eSrcB);
                end
                if (op == OP_R || op == OP_I) begin
                    checks++;
                    if (eIRtype !== (op == OP_I)) begin errors++; $display("[TB] FAIL rnd_irtype: op %b got %b expected %b", op, eIRtype, op == OP_I); end
                end
            end
            modelRet++;
        end
    endtask

    task automatic test_reset_in_store();
        bus.Opcode = STORE;
        bus.BranchTaken = 1'b0;
        @(posedge CLK);
        #1 bus.MemReady = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({bus.MemReq, bus.IorD, bus.MemWrite} !== 3'b111) begin
            errors++; $display("[TB] FAIL store_mem_phase: got %b expected 111", {bus.MemReq, bus.IorD, bus.MemWrite});
        end
        RESET = 1'b1;
        #1;
        checks++;
        if ({bus.PCwrite, bus.Retire} !== 2'b00) begin
            errors++; $display("[TB] FAIL store_reset_strobes: got %b expected 00", {bus.PCwrite, bus.Retire});
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        bus.MemReady = 1'b0;
        #1;
        checks++;
        if ({bus.MemReq, bus.IorD} !== 2'b10 || bus.InstRet !== 32'd0) begin
            errors++; $display("[TB] FAIL store_reset_fetch: got MemReq/IorD %b instret %0d expected 10 0", {bus.MemReq, bus.IorD}, bus.InstRet);
        end
        modelRet = 32'd0;
    endtask

    task automatic test_trap();
        int haltCycles;
        int strobeCycles;
        haltCycles = 0;
        strobeCycles = 0;
        bus.Opcode = 7'b1111111;
        @(posedge CLK);
        #1 bus.MemReady = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1 bus.MemReady = 1'($urandom_range(0, 1));
            #1;
            haltCycles += int'(bus.Halted);
            if ({bus.MemReq, bus.IRwrite, bus.MDRwrite, bus.ALUoutWrite, bus.RegWrite, bus.PCwrite,
                 bus.Retire, bus.MemWrite, bus.BranchEn, bus.ALUcontrol} !== 10'd0) strobeCycles++;
        end
        checks++;
        if (haltCycles !== 20) begin errors++; $display("[TB] FAIL trap_halted: got %0d cycles expected 20", haltCycles); end
        checks++;
        if (strobeCycles !== 0) begin errors++; $display("[TB] FAIL trap_strobes: got %0d active cycles expected 0", strobeCycles); end
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        bus.MemReady = 1'b0;
        #1;
        checks++;
        if ({bus.Halted, bus.MemReq, bus.IorD} !== 3'b010 || bus.InstRet !== 32'd0) begin
            errors++; $display("[TB] FAIL trap_reset: got Halted/MemReq/IorD %b instret %0d expected 010 0",
                {bus.Halted, bus.MemReq, bus.IorD}, bus.InstRet);
        end
        modelRet = 32'd0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_load_waits();
        test_branch();
        test_jal_jalr();
        test_back_to_back(40);
        test_reset_in_store();
        test_back_to_back(8);
        test_trap();
        test_back_to_back(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
